// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
//
// Buffers 10-bit samples from the core in a small FIFO and releases one
// sample to the DAC per programmable sample period. The DAC update rate is
// set only by the divider, so jitter in when the core writes samples does
// not reach the DAC. When a period elapses and the FIFO is empty, D holds
// its last value and a sticky underflow flag is raised.
//
// Ports:
//   CLK           PLL clock; all logic on the rising edge
//   reset         synchronous, active-high reset
//   in_data       sample from the core
//   in_valid      in_data holds a sample
//   in_ready      FIFO can accept a sample (push = in_valid & in_ready)
//   enable        pacing enable
//   div           sample period minus 1, in CLK cycles
//   clear_flags   clears the sticky underflow flag
//   D             registered sample to the DAC D input
//   sample_strobe one-cycle pulse in the cycle D shows a new value
//   underflow     sticky; a period elapsed with the FIFO empty
//   fill_level    current FIFO occupancy, 0..DEPTH
//
// DEPTH must be a power of two, at least 2, so that the pointers wrap by
// simple overflow.

module dac_sample_pacer #(
  parameter int                DATA_W     = 10,
  parameter int                DEPTH      = 8,
  parameter int                DIV_W      = 16,
  parameter logic [DATA_W-1:0] RESET_CODE = 10'h200
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div,
  input  logic                       clear_flags,
  output logic [DATA_W-1:0]          D,
  output logic                       sample_strobe,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DIV_W-1:0]  cnt;

  logic tick;
  logic fifo_empty;
  logic push;
  logic pop;

  // in_ready comes from the registered count only, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign in_ready   = (count != FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = in_valid & in_ready;
  assign tick       = enable & (cnt == '0);
  // Empty is judged on the registered count, so a sample pushed this
  // cycle cannot be popped until the next tick.
  assign pop        = tick & ~fifo_empty;

  assign fill_level = count;

  // Sample period divider. While disabled the counter is held at div so the
  // first tick after enabling comes a full period later; out of reset it is
  // zero, so the first enable after reset ticks at once.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= div;
    end else if (cnt == '0) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      D             <= RESET_CODE;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= pop;
      if (pop) begin
        D <= mem[rd_ptr];
      end
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (tick && fifo_empty) begin
      underflow <= 1'b1;
    end else if (clear_flags) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Testbench for dac_sample_pacer: a queue-based model checked every cycle,
// plus directed expectations computed by hand.

module tb_dac_sample_pacer;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;

  logic              CLK;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              enable;
  logic [DIV_W-1:0]  div;
  logic              clear_flags;
  logic [DATA_W-1:0] D;
  logic              sample_strobe;
  logic              underflow;
  logic [3:0]        fill_level;

  dac_sample_pacer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .RESET_CODE(10'h200)
  ) dut (
    .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .enable(enable), .div(div),
    .clear_flags(clear_flags), .D(D), .sample_strobe(sample_strobe),
    .underflow(underflow), .fill_level(fill_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; the period is a countdown of cycles left
  // before the next tick.
  int q[$];
  int m_d;
  int m_strobe;
  int m_uf;
  int m_left;
  bit m_valid = 1'b0;
  bit m_tick;
  bit m_room;

  always @(posedge CLK) begin
    if (reset) begin
      q.delete();
      m_d = 'h200; m_strobe = 0; m_uf = 0; m_left = 0;
    end else begin
      m_room = (q.size() != DEPTH);
      m_tick = 1'b0;
      if (!enable) m_left = int'(div);
      else if (m_left == 0) begin m_tick = 1'b1; m_left = int'(div); end
      else m_left = m_left - 1;
      m_strobe = 0;
      if (m_tick && q.size() > 0) begin
        m_d = q.pop_front();
        m_strobe = 1;
      end
      if (m_tick && q.size() == 0 && m_strobe == 0) m_uf = 1;
      else if (clear_flags) m_uf = 0;
      if (in_valid && m_room) q.push_back(int'(in_data));
    end
    m_valid = 1'b1;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_D", int'(D), m_d);
      check("model_strobe", int'(sample_strobe), m_strobe);
      check("model_underflow", int'(underflow), m_uf);
      check("model_fill", int'(fill_level), q.size());
      check("model_ready", int'(in_ready), int'(q.size() != DEPTH));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int strobe_k[$];
  int strobe_d[$];
  int got[$];
  int idx;
  int acc_cycle;
  bit acc;

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; enable = 1'b0;
    div = '0; clear_flags = 1'b0;
    step(); step();
    // Reset state
    check("rst_D", int'(D), 'h200);
    check("rst_strobe", int'(sample_strobe), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_fill", int'(fill_level), 0);
    check("rst_ready", int'(in_ready), 1);
    reset = 1'b0;

    // Three samples paced with div = 3
    div = 16'd3;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i);
      step();
    end
    in_valid = 1'b0;
    check("pace_fill3", int'(fill_level), 3);
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sample_strobe) begin
        strobe_k.push_back(k);
        strobe_d.push_back(int'(D));
      end
    end
    check("pace_nstrobes", strobe_k.size(), 3);
    if (strobe_k.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("pace_edge", strobe_k[i], 4 * (i + 1));
        check("pace_D", strobe_d[i], i + 1);
      end
    end
    check("pace_fill0", int'(fill_level), 0);
    check("pace_underflow", int'(underflow), 1);

    // Fill to full, then drain at div = 0 across the pointer wrap
    enable = 1'b0; div = '0; clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = DATA_W'('h10 + idx);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_data = DATA_W'('h10 + idx);
    check("full_fill", int'(fill_level), 8);
    check("full_ready", int'(in_ready), 0);
    check("full_idx", idx, 8);
    enable = 1'b1;
    acc_cycle = -1;
    for (int c = 0; c < 14; c++) begin
      acc = in_valid && in_ready;
      step();
      if (c == 0) check("full_ready_after_pop", int'(in_ready), 1);
      if (acc) begin
        idx++;
        if (idx == 9) begin
          acc_cycle = c;
          in_valid = 1'b0;
        end else in_data = DATA_W'('h10 + idx);
      end
      if (sample_strobe) got.push_back(int'(D));
    end
    check("full_9th_cycle", acc_cycle, 1);
    check("full_ngot", got.size(), 9);
    if (got.size() == 9) begin
      for (int i = 0; i < 9; i++) check("full_order", got[i], 'h10 + i);
    end

    // Underflow set/clear priority on an empty FIFO
    enable = 1'b0; clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("uf_cleared", int'(underflow), 0);
    enable = 1'b1;
    step();
    check("uf_set", int'(underflow), 1);
    check("uf_strobe", int'(sample_strobe), 0);
    check("uf_D_hold", int'(D), 'h18);
    clear_flags = 1'b1;
    step();
    check("uf_set_wins", int'(underflow), 1);
    enable = 1'b0;
    step();
    check("uf_clear", int'(underflow), 0);
    clear_flags = 1'b0;

    // Streaming at div = 0: D trails pushes by two edges
    in_valid = 1'b1; in_data = DATA_W'('h100);
    step();
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = DATA_W'('h100 + i);
      step();
      check("stream_D", int'(D), 'h100 + i - 1);
      check("stream_fill_le1", int'(fill_level <= 4'd1), 1);
      check("stream_underflow", int'(underflow), 0);
    end
    in_valid = 1'b0;
    step();
    check("stream_last", int'(D), 'h10A);
    check("stream_strobe", int'(sample_strobe), 1);
    enable = 1'b0;

    // Reset mid-operation discards buffered data
    div = 16'd100;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DATA_W'('h3A0 + i);
      step();
    end
    in_valid = 1'b0;
    enable = 1'b1;
    step();
    check("mid_fill5", int'(fill_level), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_fill0", int'(fill_level), 0);
    check("mid_D", int'(D), 'h200);
    check("mid_strobe", int'(sample_strobe), 0);
    check("mid_ready", int'(in_ready), 1);
    step();
    check("mid_first_tick_uf", int'(underflow), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_old_D", int'(D), 'h200);
      check("mid_no_strobe", int'(sample_strobe), 0);
    end
    enable = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
- Sits between the rvmyth core's 10-bit output and the avsddac D input.
- Buffers core-produced samples in a small FIFO and releases one sample to the DAC per programmable sample period, giving the DAC a jitter-free update rate independent of core write timing.
- Holds the last value and flags underflow when the core falls behind.
- Clocked from the PLL output clock, the same domain as rvmyth.

Parameters:
- DATA_W, 10, sample width (matches DAC D input).
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- DIV_W, 16, width of the sample-period divider.
- RESET_CODE, 10'h200, DAC code driven from reset until the first sample (mid-scale).

Ports:
- CLK  input  1  PLL clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  sample from rvmyth OUT.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  FIFO can accept; push = in_valid & in_ready.
- enable  input  1  pacing enable.
- div  input  DIV_W  sample period minus 1, in CLK cycles.
- clear_flags  input  1  clears sticky underflow.
- D  output  DATA_W  registered sample to avsddac D.
- sample_strobe  output  1  one-cycle pulse, coincident with the cycle D takes a new value.
- underflow  output  1  sticky; a tick found the FIFO empty.
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, overrides everything):
  - D = RESET_CODE; sample_strobe = 0; underflow = 0.
  - fill_level = 0; read/write pointers = 0; divider count = 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered samples.
- FIFO:
  - in_ready = (fill_level != DEPTH), combinational from registered count.
  - Push writes at the write pointer; the pointer wraps modulo DEPTH.
  - There is no push-while-full, even in a cycle that also pops; in_ready stays 0 while full.
  - Simultaneous push and pop: fill_level unchanged; both pointers advance.
  - No bypass: a sample pushed in cycle t is poppable no earlier than the tick in cycle t+1.
- Divider, register cnt[DIV_W-1:0]:
  - enable = 0: cnt <= div; no ticks.
  - enable = 1 and cnt == 0: tick = 1; cnt <= div.
  - enable = 1 and cnt != 0: cnt <= cnt - 1.
  - Tick period = div+1 cycles; div = 0 ticks every cycle.
  - A change to div takes effect at the next reload.
  - The first tick after enable rises occurs div+1 cycles later, since cnt was preloaded with div.
  - Exception: the first enable after reset ticks immediately, because cnt resets to 0.
- Tick with FIFO not empty:
  - D <= head entry; pop.
  - sample_strobe = 1 in the following cycle, the same cycle D shows the new value.
- Tick with FIFO empty:
  - D holds; sample_strobe = 0; underflow <= 1.
  - An underflow tick pops nothing, and a sample arriving in the same cycle is not consumed.
- underflow:
  - Cleared by clear_flags.
  - Set takes priority over clear in the same cycle.
- Minimum latency: push in cycle t, tick in t+1 → D updates at end of t+1 (2 edges).
- Otherwise D changes only on a non-empty tick; D never glitches.
- fill_level updates one cycle after the push/pop event.

Test Plan:
- Reset → D = 0x200, sample_strobe = 0, underflow = 0, fill_level = 0, in_ready = 1.
- enable = 0, push 0x001, 0x002, 0x003; then div = 3, enable = 1 → D = 0x001, 0x002, 0x003 on consecutive ticks exactly 4 cycles apart, one strobe per update, fill_level 3 → 0.
- enable = 0, in_valid held with 9 distinct words → fill_level = 8, in_ready = 0 after the 8th. Then enable with div = 0 → 9th word accepted the cycle after the first pop. D sequence matches push order, with the pointer wrap verified.
- Empty FIFO, div = 0, enable = 1 → D stays 0x200, no strobe, underflow = 1 after the first tick. clear_flags pulse → underflow = 0 unless a tick occurs in the same cycle, in which case it stays 1.
- div = 0, enable = 1, push incrementing data every cycle → D follows with 2-cycle latency; underflow stays 0 after the first sample, fill_level stays ≤ 1.
- fill_level = 5 with enable = 1, assert reset for 1 cycle → next cycle fill_level = 0, D = 0x200, no strobe. Old data never appears on D after reset.
